// File: rtl/serial_shift_sequencer.sv
// -----------------------------------------------------------------------------
// serial_shift_sequencer
//
// Takes a parallel word over a valid/ready handshake and feeds it MSB-first,
// one bit per clock, into the serial input of a SISO shift-register chain.
// Each bit is qualified by shift_en. Also reports busy and an end-of-frame
// pulse.
//
// Optional feature: define SERIAL_SEQ_PARITY_EN to append one even-parity
// bit (XOR of the captured word) after the data bits, still with frame=1.
// With the macro undefined, the PAR state and the parity register do not exist.
//
// Parameters:
//   WIDTH       bits per frame, legal range 2..32
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   load_valid  producer offers load_data
//   load_data   parallel word to serialize (sampled only on the accepting edge)
//   load_ready  sequencer can accept a word (high only in IDLE)
//   hold        stalls shifting while high (no effect in IDLE/DONE)
//   shift_en    shifter advances on this edge (= !hold while a bit is on din)
//   din         serial bit driven into the shifter
//   frame       high while data (and parity) bits are on din
//   busy        high in every state except IDLE
//   done        one-cycle pulse at end of frame
//
// Handshake: a word transfers on a rising edge where load_valid && load_ready
// are both high. load_ready does not depend on load_valid, and load_valid
// seen outside IDLE is ignored.
// -----------------------------------------------------------------------------
module serial_shift_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   input  logic             hold,
   output logic             shift_en,
   output logic             din,
   output logic             frame,
   output logic             busy,
   output logic             done
);

   // One extra bit so the counter can hold WIDTH after the last shift.
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef SERIAL_SEQ_PARITY_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_PAR   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd3
   } state_t;
`endif

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] shadow_q;
   logic [CNT_W-1:0] cnt_q;
`ifdef SERIAL_SEQ_PARITY_EN
   // Parity is captured with the word, because the shadow register is
   // destroyed by shifting before the parity bit is needed.
   logic             par_q;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Shadow word, bit counter (and captured parity)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= '0;
         cnt_q    <= '0;
`ifdef SERIAL_SEQ_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load_valid) begin
                  shadow_q <= load_data;
                  cnt_q    <= '0;
`ifdef SERIAL_SEQ_PARITY_EN
                  par_q    <= ^load_data;
`endif
               end
            end
            ST_SHIFT: begin
               if (!hold) begin
                  shadow_q <= {shadow_q[WIDTH-2:0], 1'b0};
                  cnt_q    <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next state and outputs. Every output is decoded from registered state,
   // except shift_en, which also looks at hold.
   always_comb begin
      state_d    = state_q;
      load_ready = 1'b0;
      shift_en   = 1'b0;
      din        = 1'b0;
      frame      = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            load_ready = 1'b1;
            busy       = 1'b0;
            if (load_valid) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            din      = shadow_q[WIDTH-1];
            frame    = 1'b1;
            shift_en = !hold;
            if (!hold && (cnt_q == LAST_CNT)) begin
`ifdef SERIAL_SEQ_PARITY_EN
               state_d = ST_PAR;
`else
               state_d = ST_DONE;
`endif
            end
         end
`ifdef SERIAL_SEQ_PARITY_EN
         ST_PAR: begin
            din      = par_q;
            frame    = 1'b1;
            shift_en = !hold;
            if (!hold) begin
               state_d = ST_DONE;
            end
         end
`endif
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_serial_shift_sequencer
//
// Directed bench for serial_shift_sequencer with WIDTH=8. Expected serial
// bits come from a queue built out of the word being sent. When
// SERIAL_SEQ_PARITY_EN is defined, a parity bit is added to the queue.
// -----------------------------------------------------------------------------
module tb_serial_shift_sequencer;

   localparam int W = 8;
`ifdef SERIAL_SEQ_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic         clk = 1'b0;
   logic         rst;
   logic         load_valid;
   logic [W-1:0] load_data;
   logic         load_ready;
   logic         hold;
   logic         shift_en;
   logic         din;
   logic         frame;
   logic         busy;
   logic         done;

   always #5 clk = ~clk;

   serial_shift_sequencer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .hold       (hold),
      .shift_en   (shift_en),
      .din        (din),
      .frame      (frame),
      .busy       (busy),
      .done       (done)
   );

   // ---------------- scoreboard ----------------
   int           n_tests = 0;
   int           n_fail  = 0;
   logic         exp_q[$];
   logic [W-1:0] vec;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Move to just after the next rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver ----------------
   // Sends one word, starting in IDLE, and checks every cycle until the
   // cycle after done.
   //   hold_at/hold_len : hold high for hold_len cycles while bit index
   //                      hold_at is on din (-1 means no hold)
   //   noise_at         : pulse load_valid with a junk word while bit index
   //                      noise_at is on din (-1 means no pulse)
   //   keep_valid       : leave load_valid high after the accept, offering next_data
   task automatic send_frame(input logic [W-1:0] data, input int hold_at, input int hold_len,
                             input int noise_at, input bit keep_valid,
                             input logic [W-1:0] next_data);
      int cyc;
      int sent;
      int held;
      int guard;
      exp_q.delete();
      for (int i = W - 1; i >= 0; i--) exp_q.push_back(data[i]);
      if (PAR == 1) exp_q.push_back(^data);

      hold       = 1'b0;
      load_valid = 1'b1;
      load_data  = data;
      #1;
      chk("idle_ready", load_ready, 1);
      chk("idle_busy", busy, 0);
      tick;  // accepting edge N; the bench is now in cycle N+1
      cyc   = 1;
      sent  = 0;
      held  = 0;
      guard = 0;
      if (keep_valid) load_data = next_data;
      else            load_valid = 1'b0;

      while (exp_q.size() > 0 && guard < 4 * W) begin
         hold = (sent == hold_at) && (held < hold_len);
         if (!keep_valid) begin
            load_valid = (sent == noise_at);
            load_data  = ~data;
         end
         #1;
         chk("frame", frame, 1);
         chk("busy", busy, 1);
         chk("done_early", done, 0);
         chk("ready_in_frame", load_ready, 0);
         chk("din", din, exp_q[0]);
         chk("shift_en", shift_en, !hold);
         if (hold) held++;
         else begin
            void'(exp_q.pop_front());
            sent++;
         end
         tick;
         cyc++;
         guard++;
      end
      chk("frame_drained", exp_q.size(), 0);

      if (!keep_valid) load_valid = 1'b0;
      hold = 1'b1;  // hold in DONE must not matter
      #1;
      chk("done_pulse", done, 1);
      chk("done_frame", frame, 0);
      chk("done_din", din, 0);
      chk("done_shift_en", shift_en, 0);
      chk("done_ready", load_ready, 0);
      chk("done_latency", cyc, W + PAR + hold_len + 1);
      hold = 1'b0;
      tick;
      chk("post_done", done, 0);
      chk("post_ready", load_ready, 1);
      chk("post_busy", busy, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst        = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      hold       = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_ready", load_ready, 1);
      chk("rst_shift_en", shift_en, 0);
      chk("rst_din", din, 0);
      chk("rst_frame", frame, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      repeat (2) tick;
      rst = 1'b0;

      // Basic frame
      send_frame(8'hA5, -1, 0, -1, 1'b0, 8'h00);
      // Low-heavy word (parity 1 when parity is built in)
      send_frame(8'h07, -1, 0, -1, 1'b0, 8'h00);
      // Three hold cycles while the 2nd bit is on din
      send_frame(8'hC3, 1, 3, -1, 1'b0, 8'h00);
      // load_valid kept high: 00 is accepted only after FF's done
      send_frame(8'hFF, -1, 0, -1, 1'b1, 8'h00);
      send_frame(8'h00, -1, 0, -1, 1'b0, 8'h00);
      // load_valid pulsed mid-frame is ignored
      send_frame(8'h96, -1, 0, 3, 1'b0, 8'h00);

      // Reset while bit 4 of 5A is on din
      vec        = 8'h5A;
      load_valid = 1'b1;
      load_data  = vec;
      #1;
      tick;
      load_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("pre_rst_din", din, vec[W-1-i]);
         tick;
      end
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", load_ready, 1);
      chk("mid_rst_shift_en", shift_en, 0);
      chk("mid_rst_din", din, 0);
      chk("mid_rst_frame", frame, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      tick;
      chk("mid_rst_no_done", done, 0);
      rst = 1'b0;
      tick;
      chk("after_rst_no_done", done, 0);
      chk("after_rst_ready", load_ready, 1);

      send_frame(8'h81, -1, 0, -1, 1'b0, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/serial_shift_sequencer.md
# serial_shift_sequencer

Controller that sequences a serial-in/serial-out shift register. It accepts a parallel word over a valid/ready handshake and feeds it MSB-first, one bit per cycle, into the shifter's serial input, qualified by a shift enable. It also reports busy and end-of-frame status. It sits between a parallel producer (register file or test driver) and any SISO shift-register chain in the design.

## Interface
Parameters:
- `WIDTH`, default 8: bits per frame; legal values 2–32.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `load_valid` input 1: producer offers `load_data`.
- `load_data` input WIDTH: parallel word to serialize.
- `load_ready` output 1: sequencer can accept a word.
- `hold` input 1: stalls shifting while high.
- `shift_en` output 1: shifter advances on this clock edge.
- `din` output 1: serial bit driven into the shifter.
- `frame` output 1: high while data bits (and the parity bit, if enabled) are on `din`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at end of frame.

## Operation
- FSM states: IDLE, SHIFT, PAR (present only with the parity feature), DONE.
- **IDLE**
  - `load_ready`=1.
  - On `load_valid`&&`load_ready`: capture `load_data` into the shadow register, clear the bit counter, go to SHIFT.
  - Without a handshake: stay in IDLE.
- **SHIFT**
  - `din` = shadow[WIDTH-1]; `frame`=1; `shift_en`=!`hold`.
  - When `hold`=0: on the edge, shift the shadow left by 1 and increment the counter.
  - After the bit at count WIDTH-1 is consumed, go to PAR (if enabled) or DONE.
  - When `hold`=1: shadow, counter, `din` and `frame` are frozen and `shift_en`=0.
- **PAR**
  - `din` = XOR of the captured word (even parity); `frame`=1; `shift_en`=!`hold`.
  - `hold` stalls this state the same way as SHIFT.
  - Advance to DONE on the first cycle with `hold`=0.
- **DONE**
  - `done`=1, `frame`=0, `shift_en`=0, `load_ready`=0.
  - Go to IDLE unconditionally on the next edge.
- The counter is $clog2(WIDTH)+1 bits wide and never wraps within a frame. The count WIDTH is never reached while in SHIFT.
- `load_valid` outside IDLE is ignored. `load_data` is sampled only on the accepting edge.
- `hold` in IDLE or DONE has no effect.

## Timing
- Reset values: state=IDLE, `load_ready`=1, `shift_en`=0, `din`=0, `frame`=0, `busy`=0, `done`=0; shadow=0; counter=0.
- Outputs are decoded from registered state and shadow only. There are no combinational paths from inputs to outputs, except `shift_en`, which depends on `hold`.
- Latency, with no hold: accept at edge N.
  - MSB appears on `din` in cycle N+1.
  - Bit i appears in cycle N+1+i.
  - `done` is high in cycle N+1+WIDTH, or N+2+WIDTH with parity.
  - `load_ready` returns the cycle after `done`.
- Each `hold` cycle in SHIFT or PAR adds exactly one cycle of latency.
- Minimum frame-to-frame spacing: WIDTH+2 cycles without parity, WIDTH+3 cycles with parity.
- Reset asserted mid-frame: outputs go to their reset values immediately (asynchronously). The partial frame is discarded, and `done` is not pulsed.

## Configuration
- `SERIAL_SEQ_PARITY_EN` defined:
  - The PAR state exists.
  - One even-parity bit follows the data bits with `frame`=1.
  - Frame length is WIDTH+1 shifts.
- `SERIAL_SEQ_PARITY_EN` not defined:
  - The PAR state and parity logic are absent.
  - SHIFT goes directly to DONE.
  - Frame length is WIDTH shifts.

## Test plan
- Reset, then WIDTH=8, load 8'hA5 with `hold`=0:
  - `din` = 1,0,1,0,0,1,0,1 over 8 consecutive `shift_en`=1 cycles.
  - `done` pulses exactly once, 9 cycles after accept (10 with parity, preceded by parity bit 0).
- Load 8'h07 with parity enabled:
  - Data bits 0,0,0,0,0,1,1,1, then parity bit 1.
  - `frame` is high for 9 cycles.
- Load 8'hC3 with `hold`=1 for 3 cycles after the 2nd bit:
  - `shift_en`=0 and `din`=1 are held during the hold.
  - Bit sequence is unchanged; `done` arrives 3 cycles later than without hold.
- Keep `load_valid`=1 continuously, with words 8'hFF then 8'h00:
  - Second word is accepted only in IDLE after `done`.
  - No bit is lost or duplicated; `load_ready`=0 throughout the first frame.
- Assert `rst` during bit 4 of 8'h5A:
  - All outputs go to 0 immediately, with `load_ready`=1.
  - No `done` pulse.
  - A subsequent load of 8'h81 serializes as 1,0,0,0,0,0,0,1.
- Pulse `load_valid` while busy:
  - The word is ignored; the current frame completes unchanged.
